// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-operand forwarding / load-use interlock unit.
// Holds the pipeline tag-slot record and the forwarding-mux select encodings.
package fwd_pkg;

  localparam int REG_AW = 2;
  localparam int CNT_W  = 8;

  localparam logic [1:0] FWD_BASE = 2'b00;
  localparam logic [1:0] FWD_AC   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dst: '0, wr: 1'b0, load: 1'b0};

  // A decode-stage read matches a slot only if both sides are live and the slot writes that register.
  function automatic logic slot_hit(input slot_t             s,
                                    input logic              id_valid,
                                    input logic              id_src_used,
                                    input logic [REG_AW-1:0] id_src);
    return id_valid & id_src_used & s.valid & s.wr & (s.dst == id_src);
  endfunction

endpackage

// File: rtl/fwd_slot.sv
// One pipeline tag register (valid/dst/wr/load) with async reset.
// bubble wins over load so a killed instruction never occupies the stage.
module fwd_slot
  import fwd_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SLOT_EMPTY;
    end else if (bubble) begin
      q <= SLOT_EMPTY;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use interlock control for a single-operand EX stage.
// Tracks EX/MEM destination tags, stalls one cycle on load-use, and registers the mux select.
module fwd_ctrl
  import fwd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src,
  input  logic              id_src_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              flush,
  output logic [1:0]        fwd_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_t      id_slot;
  slot_t      ex_q;
  slot_t      mem_q;
  logic       hit_ex;
  logic       hit_mem;
  logic       kill;
  logic [1:0] fwd_next;

  assign id_slot = '{valid: id_valid, dst: id_dst, wr: id_wr, load: id_load};

  assign hit_ex  = slot_hit(ex_q,  id_valid, id_src_used, id_src);
  assign hit_mem = slot_hit(mem_q, id_valid, id_src_used, id_src);

  // A load in EX cannot supply its value until MEM; the dependent op waits one cycle.
  assign stall = hit_ex & ex_q.load & ~flush;
  assign kill  = stall | flush;

  fwd_slot u_ex_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (kill),
    .d      (id_slot),
    .q      (ex_q)
  );

  // MEM always inherits whatever EX held, including an instruction older than a flush.
  fwd_slot u_mem_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  // NOTE: default assigned first so every path drives fwd_next and no latch is inferred.
  always_comb begin
    fwd_next = FWD_BASE;
    if (kill) begin
      fwd_next = FWD_BASE;
    end else if (hit_ex && !ex_q.load) begin
      fwd_next = FWD_AC;
    end else if (hit_mem) begin
      fwd_next = FWD_MEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_sel <= FWD_BASE;
    end else begin
      fwd_sel <= fwd_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed self-checking bench for fwd_ctrl: forwarding paths, load-use stall,
// flush, saturation of the stall counter and asynchronous reset.
module tb_fwd_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_src;
  logic       id_src_used;
  logic [1:0] id_dst;
  logic       id_wr;
  logic       id_load;
  logic       flush;
  logic [1:0] fwd_sel;
  logic       stall;
  logic [7:0] stall_cnt;

  int         n_cmp;
  int         n_err;
  logic [7:0] exp_cnt;

  fwd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_dst      (id_dst),
    .id_wr       (id_wr),
    .id_load     (id_load),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] src, input logic used,
                       input logic [1:0] dst, input logic wr, input logic ld);
    id_valid    = v;
    id_src      = src;
    id_src_used = used;
    id_dst      = dst;
    id_wr       = wr;
    id_load     = ld;
    flush       = 1'b0;
  endtask

  task automatic nop();
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    nop();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 1'b1);
    tick();
    tick();
    drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL reset_fwd: got %b want 00", fwd_sel); end
    n_cmp++; if (stall_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    tick();
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL reset_fwd_clk: got %b want 00", fwd_sel); end
    rst = 1'b0;
    exp_cnt = 8'd0;
    clear();
  endtask

  task automatic test_ex_forward();
    drive(1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL ex_fwd_stall0: got %b want 0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL ex_fwd_first: got %b want 00", fwd_sel); end
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL ex_fwd_stall1: got %b want 0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 2'b01) begin n_err++; $display("FAIL ex_fwd_sel: got %b want 01", fwd_sel); end
    nop();
    tick();
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL ex_fwd_after: got %b want 00", fwd_sel); end
    clear();
  endtask

  task automatic test_mem_forward();
    drive(1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0);
    tick();
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL mem_fwd_indep: got %b want 00", fwd_sel); end
    drive(1'b1, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mem_fwd_stall: got %b want 0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 2'b10) begin n_err++; $display("FAIL mem_fwd_sel: got %b want 10", fwd_sel); end
    clear();
  endtask

  task automatic test_load_use();
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL lu_cnt_before: got %0d want %0d", stall_cnt, exp_cnt); end
    drive(1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 1'b1);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_load: got %b want 0", stall); end
    tick();
    drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_on: got %b want 1", stall); end
    tick();
    exp_cnt = exp_cnt + 8'd1;
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL lu_cnt_after: got %0d want %0d", stall_cnt, exp_cnt); end
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL lu_fwd_bubble: got %b want 00", fwd_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_once: got %b want 0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 2'b10) begin n_err++; $display("FAIL lu_fwd_mem: got %b want 10", fwd_sel); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL lu_cnt_hold: got %0d want %0d", stall_cnt, exp_cnt); end
    clear();
  endtask

  task automatic test_flush();
    drive(1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL flush_fwd: got %b want 00", fwd_sel); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    clear();
    drive(1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL flush_kills_fwd: got %b want 00", fwd_sel); end
    clear();
  endtask

  task automatic test_no_use();
    drive(1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL nouse_fwd: got %b want 00", fwd_sel); end
    clear();
    drive(1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b1);
    tick();
    drive(1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL novalid_stall: got %b want 0", stall); end
    tick();
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL novalid_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    clear();
  endtask

  task automatic test_ex_priority();
    drive(1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'd2, 1'b0, 2'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (fwd_sel !== 2'b01) begin n_err++; $display("FAIL prio_fwd: got %b want 01", fwd_sel); end
    clear();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 1'b1);
      tick();
      drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0);
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sat_stall[%0d]: got %b want 1", i, stall); end
      tick();
      if (exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
      tick();
    end
    n_cmp++; if (stall_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt: got %0d want 255", stall_cnt); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_cnt_model: got %0d want %0d", stall_cnt, exp_cnt); end
    clear();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'd2, 1'b1, 2'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rms_stall_pre: got %b want 1", stall); end
    n_cmp++; if (fwd_sel !== 2'b01) begin n_err++; $display("FAIL rms_fwd_pre: got %b want 01", fwd_sel); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL rms_cnt_pre: got %0d want %0d", stall_cnt, exp_cnt); end
    rst = 1'b1;
    #1;
    exp_cnt = 8'd0;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rms_stall: got %b want 0", stall); end
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL rms_fwd: got %b want 00", fwd_sel); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL rms_cnt: got %0d want 0", stall_cnt); end
    tick();
    rst = 1'b0;
    drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rms_post_stall: got %b want 0", stall); end
    tick();
    n_cmp++; if (fwd_sel !== 2'b00) begin n_err++; $display("FAIL rms_post_fwd: got %b want 00", fwd_sel); end
    n_cmp++; if (stall_cnt !== exp_cnt) begin n_err++; $display("FAIL rms_post_cnt: got %0d want 0", stall_cnt); end
    clear();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = 8'd0;
    rst     = 1'b1;
    nop();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_flush();
    test_no_use();
    test_ex_priority();
    test_saturate();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
